// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- handshaked pipeline stage register with a 2-entry skid buffer.
//
// Moves a control payload and a data payload between two pipeline stages with
// valid/ready flow control. The head (main) register drives the outputs; the
// skid register catches one extra entry so that in_ready can come straight
// from a flop, with no combinational path from out_ready.
// Hazard-unit controls: stall freezes the stage, and flush squashes its contents.
//
// Parameters:
//   CTRL_W     - control payload width; ctrl is zeroed on flush/reset and masked when invalid
//   DATA_W     - data payload width
//   CLEAR_DATA - 1: data registers are also zeroed on flush, 0: data is held
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   flush, stall        - squash all contents / freeze both handshakes this cycle
//   in_valid, in_ready  - upstream handshake (in_ready is registered)
//   in_ctrl, in_data    - upstream payload
//   out_valid, out_ready- downstream handshake
//   out_ctrl, out_data  - head-entry payload
//
// Optional build macro PIPE_STAGE_STATS_EN adds the saturating 16-bit counters
// bubble_cnt (cycles with out_valid=0 and no stall) and flush_cnt (flushes
// that hit a non-empty stage). Only rst_n clears these counters.

module pipe_stage_reg #(
    parameter int CTRL_W     = 16,
    parameter int DATA_W     = 128,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [15:0]       bubble_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nstate;
    logic              r_in_ready;
    logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
    logic [DATA_W-1:0] r_main_data, r_skid_data;

    logic w_push, w_pop;
    logic w_ld_main_in, w_ld_skid_in, w_ld_main_skid;

    assign out_valid = (r_state != EMPTY);
    assign in_ready  = r_in_ready;
    assign out_ctrl  = out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;

    assign w_push = in_valid & r_in_ready & ~stall;
    assign w_pop  = out_valid & out_ready & ~stall;

    // Next-state and register-load selects.
    always_comb begin
        w_nstate       = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_skid_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        if (flush) begin
            w_nstate = EMPTY;
        end else if (!stall) begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_nstate     = ONE;
                        w_ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_push) begin
                        w_nstate     = TWO;
                        w_ld_skid_in = 1'b1;
                    end else if (w_pop) begin
                        w_nstate = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can happen
                    if (w_pop) begin
                        w_nstate       = ONE;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: w_nstate = EMPTY;
            endcase
        end
    end

    // State register; in_ready is decoded from the next state so that it is a
    // flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_nstate;
            r_in_ready <= (w_nstate != TWO);
        end
    end

    // Payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
            if (CLEAR_DATA != 0) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end
        end else begin
            if (w_ld_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_ld_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_ld_skid_in) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] r_bubble_cnt, r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (!out_valid && !stall && r_bubble_cnt != 16'hFFFF)
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            if (flush && out_valid && r_flush_cnt != 16'hFFFF)
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

endmodule
